// File: rtl/id_pkg.sv
// id_pkg -- shared constants and types for the instruction-decode queue.
//
// Holds the RV32I opcode and funct3 encodings, the ALU operation and
// result-select codes driven on the decode outputs, the immediate-format
// enum and its extraction helper, the output-register state enum, and the
// packed control bundle carried from decoder to output register.

package id_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE  = 3'd1, F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB   = 3'd0, F3_LH   = 3'd1, F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4, F3_LHU  = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0, F3_SH   = 3'd1, F3_SW   = 3'd2;
  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL  = 3'd1, F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3, F3_XOR  = 3'd4, F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6, F3_AND  = 3'd7;

  // ALU operation codes
  localparam logic [7:0] ALU_NOP   = 8'h00;
  localparam logic [7:0] ALU_ADD   = 8'h01, ALU_SUB  = 8'h02, ALU_SLL  = 8'h03;
  localparam logic [7:0] ALU_SLT   = 8'h04, ALU_SLTU = 8'h05, ALU_XOR  = 8'h06;
  localparam logic [7:0] ALU_SRL   = 8'h07, ALU_SRA  = 8'h08, ALU_OR   = 8'h09;
  localparam logic [7:0] ALU_AND   = 8'h0A, ALU_LUI  = 8'h0B, ALU_AUIPC = 8'h0C;
  localparam logic [7:0] ALU_JAL   = 8'h0D, ALU_JALR = 8'h0E;
  localparam logic [7:0] ALU_BEQ   = 8'h10, ALU_BNE  = 8'h11, ALU_BLT  = 8'h14;
  localparam logic [7:0] ALU_BGE   = 8'h15, ALU_BLTU = 8'h16, ALU_BGEU = 8'h17;
  localparam logic [7:0] ALU_LB    = 8'h20, ALU_LH   = 8'h21, ALU_LW   = 8'h22;
  localparam logic [7:0] ALU_LBU   = 8'h24, ALU_LHU  = 8'h25;
  localparam logic [7:0] ALU_SB    = 8'h28, ALU_SH   = 8'h29, ALU_SW   = 8'h2A;

  // Result-select codes
  localparam logic [2:0] SEL_NOP    = 3'd0, SEL_ARITH = 3'd1, SEL_LOGIC = 3'd2;
  localparam logic [2:0] SEL_SHIFT  = 3'd3, SEL_JUMP  = 3'd4, SEL_MEM   = 3'd5;
  localparam logic [2:0] SEL_BRANCH = 3'd6, SEL_UPPER = 3'd7;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT
  } imm_fmt_e;

  typedef enum logic {OUT_EMPTY, OUT_HELD} out_state_e;

  typedef struct packed {
    logic [7:0] aluop;
    logic [2:0] alusel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_read;
    logic       rs2_read;
    logic       wreg;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{aluop: ALU_NOP, alusel: SEL_NOP, default: '0};

  // 32-bit immediate for a given format; callers sign-extend to XLEN.
  function automatic logic [31:0] imm32(imm_fmt_e fmt, logic [31:0] inst);
    case (fmt)
      IMM_I:     return {{20{inst[31]}}, inst[31:20]};
      IMM_S:     return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     return {inst[31:12], 12'h000};
      IMM_J:     return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_SHAMT: return {27'd0, inst[24:20]};
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/id_dec.sv
// id_dec -- purely combinational RV32I decoder.
//
// Ports:
//   pc     in   XLEN  PC of the instruction (passed through as dec_pc)
//   inst   in   32    raw instruction word
//   dec_pc out  XLEN  PC of the decoded instruction
//   ctrl   out  ctrl_t ALU op/select, register addresses, enables, illegal
//   imm    out  XLEN  sign-extended immediate
//
// Register address fields pass through from the instruction bits for legal
// instructions; the read/write enables say which ones matter. Illegal
// encodings collapse to the NOP bundle with only the illegal flag set.

module id_dec
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] dec_pc,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm
);

  logic [2:0] funct3;
  imm_fmt_e   fmt;
  logic       legal;

  assign funct3 = inst[14:12];
  assign dec_pc = pc;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ctrl     = CTRL_NOP;
    fmt      = IMM_NONE;
    legal    = 1'b1;
    ctrl.rs1 = inst[19:15];
    ctrl.rs2 = inst[24:20];
    ctrl.rd  = inst[11:7];
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        ctrl.aluop  = (inst[6:0] == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
        ctrl.alusel = SEL_UPPER;
        ctrl.wreg   = 1'b1;
        fmt         = IMM_U;
      end
      OPC_JAL: begin
        ctrl.aluop  = ALU_JAL;
        ctrl.alusel = SEL_JUMP;
        ctrl.wreg   = 1'b1;
        fmt         = IMM_J;
      end
      OPC_JALR: begin
        legal         = (funct3 == 3'b000);
        ctrl.aluop    = ALU_JALR;
        ctrl.alusel   = SEL_JUMP;
        ctrl.rs1_read = 1'b1;
        ctrl.wreg     = 1'b1;
        fmt           = IMM_I;
      end
      OPC_BRANCH: begin
        ctrl.alusel   = SEL_BRANCH;
        ctrl.rs1_read = 1'b1;
        ctrl.rs2_read = 1'b1;
        fmt           = IMM_B;
        case (funct3)
          F3_BEQ:  ctrl.aluop = ALU_BEQ;
          F3_BNE:  ctrl.aluop = ALU_BNE;
          F3_BLT:  ctrl.aluop = ALU_BLT;
          F3_BGE:  ctrl.aluop = ALU_BGE;
          F3_BLTU: ctrl.aluop = ALU_BLTU;
          F3_BGEU: ctrl.aluop = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        ctrl.alusel   = SEL_MEM;
        ctrl.rs1_read = 1'b1;
        ctrl.wreg     = 1'b1;
        fmt           = IMM_I;
        case (funct3)
          F3_LB:   ctrl.aluop = ALU_LB;
          F3_LH:   ctrl.aluop = ALU_LH;
          F3_LW:   ctrl.aluop = ALU_LW;
          F3_LBU:  ctrl.aluop = ALU_LBU;
          F3_LHU:  ctrl.aluop = ALU_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        ctrl.alusel   = SEL_MEM;
        ctrl.rs1_read = 1'b1;
        ctrl.rs2_read = 1'b1;
        fmt           = IMM_S;
        case (funct3)
          F3_SB:   ctrl.aluop = ALU_SB;
          F3_SH:   ctrl.aluop = ALU_SH;
          F3_SW:   ctrl.aluop = ALU_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM, OPC_OP: begin
        ctrl.rs1_read = 1'b1;
        ctrl.wreg     = 1'b1;
        if (inst[6:0] == OPC_OP) begin
          ctrl.rs2_read = 1'b1;
        end else begin
          // Shift-immediates carry a 5-bit shamt, never sign-extended.
          fmt = (funct3 == F3_SLL || funct3 == F3_SR) ? IMM_SHAMT : IMM_I;
        end
        case (funct3)
          F3_ADD: begin
            // inst[30] means SUB only for register-register; for ADDI it is
            // just an immediate bit.
            ctrl.aluop  = (inst[6:0] == OPC_OP && inst[30]) ? ALU_SUB : ALU_ADD;
            ctrl.alusel = SEL_ARITH;
          end
          F3_SLL:  begin ctrl.aluop = ALU_SLL;  ctrl.alusel = SEL_SHIFT; end
          F3_SLT:  begin ctrl.aluop = ALU_SLT;  ctrl.alusel = SEL_ARITH; end
          F3_SLTU: begin ctrl.aluop = ALU_SLTU; ctrl.alusel = SEL_ARITH; end
          F3_XOR:  begin ctrl.aluop = ALU_XOR;  ctrl.alusel = SEL_LOGIC; end
          F3_SR: begin
            ctrl.aluop  = inst[30] ? ALU_SRA : ALU_SRL;
            ctrl.alusel = SEL_SHIFT;
          end
          F3_OR:   begin ctrl.aluop = ALU_OR;   ctrl.alusel = SEL_LOGIC; end
          default: begin ctrl.aluop = ALU_AND;  ctrl.alusel = SEL_LOGIC; end
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl         = CTRL_NOP;
      ctrl.illegal = 1'b1;
      fmt          = IMM_NONE;
    end
    // Writes to x0 are architecturally discarded; suppress them here.
    if (ctrl.rd == 5'd0) ctrl.wreg = 1'b0;
  end

  assign imm = XLEN'($signed(imm32(fmt, inst)));

endmodule

// File: rtl/id_queue.sv
// id_queue -- instruction queue with a decoded output register.
//
// A DEPTH-entry circular FIFO of {pc, inst} feeds one output register that
// holds the decoded fields of the oldest instruction. Valid/ready on both
// sides; flush_i empties FIFO and output register on the next edge.
//
// Ports:
//   clk, rst (sync, active-high)
//   in_valid_i / in_ready_o / in_pc_i / in_inst_i    fetch side
//   flush_i                                          discard everything
//   out_valid_o / out_ready_i / out_pc_o             execute side
//   out_aluop_o, out_alusel_o, out_rs1_o, out_rs2_o, out_rd_o,
//   out_rs1_read_o, out_rs2_read_o, out_wreg_o, out_imm_o, out_illegal_o
//   count_o                                          FIFO occupancy
//
// Build option: define ID_QUEUE_BYPASS_EN to let a push into an empty FIFO
// load the output register directly (one-edge latency, FIFO untouched).

module id_queue
  import id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [XLEN-1:0]            in_pc_i,
  input  logic [31:0]                in_inst_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [7:0]                 out_aluop_o,
  output logic [2:0]                 out_alusel_o,
  output logic [4:0]                 out_rs1_o,
  output logic [4:0]                 out_rs2_o,
  output logic [4:0]                 out_rd_o,
  output logic                       out_rs1_read_o,
  output logic                       out_rs2_read_o,
  output logic                       out_wreg_o,
  output logic [XLEN-1:0]            out_imm_o,
  output logic                       out_illegal_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  out_state_e      state;

  logic [XLEN-1:0] pc_q, imm_q;
  ctrl_t           ctrl_q;

  logic            push, pop, can_load, fifo_wr, fifo_rd, load_bypass;
  logic [XLEN-1:0] head_pc, head_imm, nxt_pc, nxt_imm;
  ctrl_t           head_ctrl, nxt_ctrl;

  assign in_ready_o  = (count < CW'(DEPTH));
  assign out_valid_o = (state == OUT_HELD);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  // Output register can take a new instruction this edge.
  assign can_load    = !out_valid_o || pop;
  assign fifo_rd     = can_load && (count != '0);
  assign fifo_wr     = push && !load_bypass;

  id_dec #(.XLEN(XLEN)) u_dec_head (
    .pc     (pc_mem[rd_ptr]),
    .inst   (inst_mem[rd_ptr]),
    .dec_pc (head_pc),
    .ctrl   (head_ctrl),
    .imm    (head_imm)
  );

`ifdef ID_QUEUE_BYPASS_EN
  logic [XLEN-1:0] in_dec_pc, in_dec_imm;
  ctrl_t           in_dec_ctrl;

  id_dec #(.XLEN(XLEN)) u_dec_in (
    .pc     (in_pc_i),
    .inst   (in_inst_i),
    .dec_pc (in_dec_pc),
    .ctrl   (in_dec_ctrl),
    .imm    (in_dec_imm)
  );

  assign load_bypass = push && (count == '0) && can_load;
  assign nxt_pc      = load_bypass ? in_dec_pc   : head_pc;
  assign nxt_imm     = load_bypass ? in_dec_imm  : head_imm;
  assign nxt_ctrl    = load_bypass ? in_dec_ctrl : head_ctrl;
`else
  assign load_bypass = 1'b0;
  assign nxt_pc      = head_pc;
  assign nxt_imm     = head_imm;
  assign nxt_ctrl    = head_ctrl;
`endif

  // NOTE: FIFO storage has no reset; entries are only read behind the
  // pointers and count, which are reset, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      pc_mem[wr_ptr]   <= in_pc_i;
      inst_mem[wr_ptr] <= in_inst_i;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= OUT_EMPTY;
      pc_q   <= '0;
      imm_q  <= '0;
      ctrl_q <= CTRL_NOP;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(fifo_wr) - CW'(fifo_rd);
      if (fifo_rd || load_bypass) begin
        state  <= OUT_HELD;
        pc_q   <= nxt_pc;
        imm_q  <= nxt_imm;
        ctrl_q <= nxt_ctrl;
      end else if (pop) begin
        state <= OUT_EMPTY;
      end
    end
  end

  assign count_o        = count;
  assign out_pc_o       = pc_q;
  assign out_imm_o      = imm_q;
  assign out_aluop_o    = ctrl_q.aluop;
  assign out_alusel_o   = ctrl_q.alusel;
  assign out_rs1_o      = ctrl_q.rs1;
  assign out_rs2_o      = ctrl_q.rs2;
  assign out_rd_o       = ctrl_q.rd;
  assign out_rs1_read_o = ctrl_q.rs1_read;
  assign out_rs2_read_o = ctrl_q.rs2_read;
  assign out_wreg_o     = ctrl_q.wreg;
  assign out_illegal_o  = ctrl_q.illegal;

endmodule

// File: tb/tb_id_queue.sv
// tb_id_queue -- self-checking bench for id_queue (DEPTH=4, XLEN=32).
// A queue-based reference model tracks FIFO contents and the output slot;
// a table-driven reference decoder derives expected fields from the
// instruction word. Honours ID_QUEUE_BYPASS_EN when defined.

module tb_id_queue;
  import id_pkg::*;

  localparam int DEPTH = 4;

`ifdef ID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_imm;
  logic [7:0]  out_aluop;
  logic [2:0]  out_alusel, count;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rs1_read, out_rs2_read, out_wreg, out_illegal;

  always #5 clk = ~clk;

  id_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_pc_i(in_pc), .in_inst_i(in_inst), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
    .out_aluop_o(out_aluop), .out_alusel_o(out_alusel),
    .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_rd_o(out_rd),
    .out_rs1_read_o(out_rs1_read), .out_rs2_read_o(out_rs2_read),
    .out_wreg_o(out_wreg), .out_imm_o(out_imm), .out_illegal_o(out_illegal),
    .count_o(count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference decoder ----------------
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  rs1, rs2, rd;
    logic        r1, r2, w, ill;
    logic [31:0] imm;
  } exp_t;

  localparam logic [7:0] ALU_TAB [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                          ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [2:0] SEL_TAB [8] = '{SEL_ARITH, SEL_SHIFT, SEL_ARITH, SEL_ARITH,
                                          SEL_LOGIC, SEL_SHIFT, SEL_LOGIC, SEL_LOGIC};
  localparam logic [7:0] BR_TAB  [8] = '{ALU_BEQ, ALU_BNE, ALU_NOP, ALU_NOP,
                                          ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
  localparam logic [7:0] LD_TAB  [8] = '{ALU_LB, ALU_LH, ALU_LW, ALU_NOP,
                                          ALU_LBU, ALU_LHU, ALU_NOP, ALU_NOP};
  localparam logic [7:0] ST_TAB  [8] = '{ALU_SB, ALU_SH, ALU_SW, ALU_NOP,
                                          ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP};

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int   i_imm, s_imm, b_imm, j_imm, f3;
    bit   legal;
    i_imm = $signed(w[31:20]);
    s_imm = $signed({w[31:25], w[11:7]});
    b_imm = $signed({w[31], w[7], w[30:25], w[11:8]}) * 2;
    j_imm = $signed({w[31], w[19:12], w[20], w[30:21]}) * 2;
    f3    = int'(w[14:12]);
    e     = '0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    legal = 1'b1;
    case (w[6:0])
      7'h37: begin e.aluop = ALU_LUI;   e.alusel = SEL_UPPER; e.w = 1; e.imm = {w[31:12], 12'h0}; end
      7'h17: begin e.aluop = ALU_AUIPC; e.alusel = SEL_UPPER; e.w = 1; e.imm = {w[31:12], 12'h0}; end
      7'h6F: begin e.aluop = ALU_JAL;   e.alusel = SEL_JUMP;  e.w = 1; e.imm = 32'(j_imm); end
      7'h67: begin
        legal = (f3 == 0);
        e.aluop = ALU_JALR; e.alusel = SEL_JUMP; e.r1 = 1; e.w = 1; e.imm = 32'(i_imm);
      end
      7'h63: begin
        legal = (f3 != 2 && f3 != 3);
        e.aluop = BR_TAB[f3]; e.alusel = SEL_BRANCH; e.r1 = 1; e.r2 = 1; e.imm = 32'(b_imm);
      end
      7'h03: begin
        legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        e.aluop = LD_TAB[f3]; e.alusel = SEL_MEM; e.r1 = 1; e.w = 1; e.imm = 32'(i_imm);
      end
      7'h23: begin
        legal = (f3 <= 2);
        e.aluop = ST_TAB[f3]; e.alusel = SEL_MEM; e.r1 = 1; e.r2 = 1; e.imm = 32'(s_imm);
      end
      7'h13, 7'h33: begin
        e.aluop = ALU_TAB[f3]; e.alusel = SEL_TAB[f3]; e.r1 = 1; e.w = 1;
        if (f3 == 5 && w[30]) e.aluop = ALU_SRA;
        if (w[6:0] == 7'h33) begin
          e.r2 = 1;
          if (f3 == 0 && w[30]) e.aluop = ALU_SUB;
        end else begin
          e.imm = (f3 == 1 || f3 == 5) ? {27'd0, w[24:20]} : 32'(i_imm);
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e     = '0;
      e.ill = 1'b1;
    end
    if (e.rd == 0) e.w = 1'b0;
    return e;
  endfunction

  // ---------------- reference queue model ----------------
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} entry_t;
  entry_t m_fifo[$];
  entry_t m_out;
  bit     m_hv;

  // Next-state of the model for the inputs currently driven.
  function automatic void model_step();
    bit push, pop, can_load;
    push = in_valid && (m_fifo.size() < DEPTH);
    pop  = m_hv && out_ready;
    if (rst || flush) begin
      m_fifo.delete();
      m_hv = 1'b0;
      return;
    end
    can_load = !m_hv || pop;
    if (can_load && m_fifo.size() > 0) begin
      m_out = m_fifo.pop_front();
      m_hv  = 1'b1;
    end else if (BYP && can_load && push) begin
      m_out = '{pc: in_pc, inst: in_inst};
      m_hv  = 1'b1;
      push  = 1'b0;
    end else if (pop) begin
      m_hv = 1'b0;
    end
    if (push) m_fifo.push_back('{pc: in_pc, inst: in_inst});
  endfunction

  task automatic compare_all();
    exp_t e;
    check("count", count, m_fifo.size());
    check("in_ready", in_ready, m_fifo.size() < DEPTH);
    check("out_valid", out_valid, m_hv);
    if (m_hv) begin
      e = ref_decode(m_out.inst);
      check("pc", out_pc, m_out.pc);
      check("aluop", out_aluop, e.aluop);
      check("alusel", out_alusel, e.alusel);
      check("rs1", out_rs1, e.rs1);
      check("rs2", out_rs2, e.rs2);
      check("rd", out_rd, e.rd);
      check("rs1_read", out_rs1_read, e.r1);
      check("rs2_read", out_rs2_read, e.r2);
      check("wreg", out_wreg, e.w);
      check("imm", out_imm, e.imm);
      check("illegal", out_illegal, e.ill);
    end
  endtask

  // One clock: drive inputs (at negedge), advance model, sample at next negedge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl, input logic r);
    in_valid = v; in_pc = pc; in_inst = inst; out_ready = rdy; flush = fl; rst = r;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 3; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                              7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
    logic [31:0] w;
    w      = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int npop;

    // Reset
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("rst_count", count, 0);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_aluop", out_aluop, ALU_NOP);
    check("rst_imm", out_imm, 0);
    check("rst_pc", out_pc, 0);
    check("rst_rd", out_rd, 0);

    // ADDI x1,x0,-1
    cycle(1'b1, 32'h1000, 32'hFFF00093, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("addi_valid", out_valid, 1);
    check("addi_aluop", out_aluop, ALU_ADD);
    check("addi_rd", out_rd, 1);
    check("addi_rs1_read", out_rs1_read, 1);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    drain();

    // Back-pressure: 6 attempts, 5 accepted, 1 held + 4 queued
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'h3000 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0, 1'b0);
    check("full_count", count, 4);
    check("full_ready", in_ready, 0);
    check("full_valid", out_valid, 1);
    npop = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        check("bp_order_pc", out_pc, 32'h3000 + 32'(4 * npop));
        npop++;
      end
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    end
    check("bp_npop", npop, 5);

    // Streaming: 3*DEPTH instructions with continuous ready
    npop = 0;
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin
      if (out_valid) begin
        check("stream_pc", out_pc, 32'h2000 + 32'(4 * npop));
        npop++;
      end
      if (i < 3 * DEPTH)
        cycle(1'b1, 32'h2000 + 32'(4 * i), rand_inst(), 1'b1, 1'b0, 1'b0);
      else
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    end
    check("stream_npop", npop, 3 * DEPTH);

    // BEQ offset -4, then JAL x0
    cycle(1'b1, 32'h4000, 32'hFE000EE3, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    check("beq_aluop", out_aluop, ALU_BEQ);
    drain();
    cycle(1'b1, 32'h4004, 32'h0000006F, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("jal_x0_wreg", out_wreg, 0);
    check("jal_aluop", out_aluop, ALU_JAL);
    drain();

    // Flush with simultaneous push while count is 3
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h5000 + 32'(4 * i), 32'h00100093, 1'b0, 1'b0, 1'b0);
    check("preflush_count", count, 3);
    cycle(1'b1, 32'h5100, 32'h00100093, 1'b1, 1'b1, 1'b0);
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    check("flush_dropped", out_valid, 0);

    // Illegal opcode, and first-edge latency (bypass-dependent)
    cycle(1'b1, 32'h6000, 32'h0000007F, 1'b0, 1'b0, 1'b0);
    check("lat1_valid", out_valid, BYP);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("ill_flag", out_illegal, 1);
    check("ill_wreg", out_wreg, 0);
    check("ill_aluop", out_aluop, ALU_NOP);
    drain();

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom, rand_inst(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 299) == 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
